// File: rtl/lpc_io_cycle_ctrl_if.sv
// LPC pin and register-bank signals of lpc_io_cycle_ctrl.
// Port 80 snoop signals exist only when LPC_PORT80_SNOOP_EN is defined.
interface lpc_io_cycle_ctrl_if;
    logic        LFRAME_N;
    logic [3:0]  LAD_In;
    logic [3:0]  LAD_Out;
    logic        LAD_OE;
    logic [15:0] DevAddr;
    logic        RdDev_En;
    logic [7:0]  RdDev_Data;
    logic        WrDev_En;
    logic [7:0]  WrDev_Data;
    logic        Busy;
`ifdef LPC_PORT80_SNOOP_EN
    logic [7:0]  Port80Data;
    logic        Port80Vld;
`endif

    modport master (
`ifdef LPC_PORT80_SNOOP_EN
        input  Port80Data, Port80Vld,
`endif
        output LFRAME_N, LAD_In, RdDev_Data,
        input  LAD_Out, LAD_OE, DevAddr, RdDev_En,
        input  WrDev_En, WrDev_Data, Busy
    );

    modport slave (
`ifdef LPC_PORT80_SNOOP_EN
        output Port80Data, Port80Vld,
`endif
        input  LFRAME_N, LAD_In, RdDev_Data,
        output LAD_Out, LAD_OE, DevAddr, RdDev_En,
        output WrDev_En, WrDev_Data, Busy
    );
endinterface

// File: rtl/lpc_io_cycle_ctrl.sv
// LPC peripheral I/O read/write cycle controller for the CPLD register bank.
// Optional port 80 write snooping is enabled by defining LPC_PORT80_SNOOP_EN.
module lpc_io_cycle_ctrl #(
    parameter logic [15:0] BASE_ADDR  = 16'h0800,
    parameter int unsigned WAIT_SYNCS = 2
) (
    input  logic               Mclk,
    input  logic               Reset,
    lpc_io_cycle_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, START, ADDR, WDATA, HTAR1, HTAR2,
        SYNCW, SYNCR, RDATA, PTAR1, PTAR2, SKIP
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_SYNCS - 1);
    localparam logic [3:0] T_IORD    = 4'b0000;
    localparam logic [3:0] T_IOWR    = 4'b0010;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        is_write, snoop, snoop_hit;
    logic        in_window, in_frame, lad_start;
    logic [15:0] dev_addr, addr_nxt;
    logic [7:0]  wr_data, rd_hold;

    assign addr_nxt  = {dev_addr[11:0], bus.LAD_In};
    assign in_window = addr_nxt[15:5] == BASE_ADDR[15:5];
    assign lad_start = !bus.LFRAME_N && bus.LAD_In == 4'b0000;
    assign in_frame  = !(state inside {IDLE, START, SKIP});

`ifdef LPC_PORT80_SNOOP_EN
    assign snoop_hit = is_write && addr_nxt == 16'h0080;
`else
    assign snoop_hit = 1'b0;
`endif

    always_ff @(posedge Mclk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.LAD_Out  = 4'hF;
        bus.LAD_OE   = 1'b0;
        bus.RdDev_En = 1'b0;
        bus.WrDev_En = 1'b0;
        unique case (state)
            IDLE, SKIP: if (lad_start) state_nxt = START;
            START: begin
                if (!bus.LFRAME_N)
                    state_nxt = lad_start ? START : SKIP;
                else if (bus.LAD_In == T_IORD || bus.LAD_In == T_IOWR)
                    state_nxt = ADDR;
                else
                    state_nxt = SKIP;
            end
            ADDR: if (cnt == 4'd3) begin
                if (in_window)      state_nxt = is_write ? WDATA : HTAR1;
                else if (snoop_hit) state_nxt = WDATA;
                else                state_nxt = SKIP;
            end
            WDATA: if (cnt == 4'd1) state_nxt = snoop ? SKIP : HTAR1;
            HTAR1: state_nxt = HTAR2;
            HTAR2: begin
                bus.RdDev_En = !is_write;
                state_nxt    = is_write ? SYNCR : SYNCW;
            end
            SYNCW: begin
                bus.LAD_OE  = 1'b1;
                bus.LAD_Out = 4'b0101;
                if (cnt == WAIT_LAST) state_nxt = SYNCR;
            end
            SYNCR: begin
                bus.LAD_OE   = 1'b1;
                bus.LAD_Out  = 4'b0000;
                bus.WrDev_En = is_write;
                state_nxt    = is_write ? PTAR1 : RDATA;
            end
            RDATA: begin
                bus.LAD_OE  = 1'b1;
                bus.LAD_Out = cnt[0] ? rd_hold[7:4] : rd_hold[3:0];
                if (cnt == 4'd1) state_nxt = PTAR1;
            end
            PTAR1: begin
                bus.LAD_OE = 1'b1;
                state_nxt  = PTAR2;
            end
            PTAR2:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A host abort ends any frame in progress
        if (in_frame && !bus.LFRAME_N)
            state_nxt = (bus.LAD_In == 4'b0000) ? START : SKIP;
    end

    always_ff @(posedge Mclk) begin
        if (Reset) begin
            cnt      <= 4'd0;
            is_write <= 1'b0;
            snoop    <= 1'b0;
            dev_addr <= 16'h0000;
            wr_data  <= 8'h00;
            rd_hold  <= 8'h00;
        end else begin
            cnt <= (state_nxt == state) ? cnt + 4'd1 : 4'd0;
            if (state == START && bus.LFRAME_N)
                is_write <= bus.LAD_In == T_IOWR;
            if (state == ADDR && bus.LFRAME_N)
                dev_addr <= addr_nxt;
            if (state == ADDR && cnt == 4'd3)
                snoop <= snoop_hit;
            if (state == WDATA && bus.LFRAME_N && !snoop)
                wr_data <= {bus.LAD_In, wr_data[7:4]};
            // Registered read mux has settled by the last wait state
            if (state == SYNCW && cnt == WAIT_LAST)
                rd_hold <= bus.RdDev_Data;
        end
    end

`ifdef LPC_PORT80_SNOOP_EN
    logic [3:0] p80_lo;
    logic [7:0] p80_data;
    logic       p80_vld;

    always_ff @(posedge Mclk) begin
        if (Reset) begin
            p80_lo   <= 4'h0;
            p80_data <= 8'h00;
            p80_vld  <= 1'b0;
        end else begin
            p80_vld <= 1'b0;
            if (state == WDATA && snoop && bus.LFRAME_N) begin
                if (cnt == 4'd0) begin
                    p80_lo <= bus.LAD_In;
                end else begin
                    p80_data <= {bus.LAD_In, p80_lo};
                    p80_vld  <= 1'b1;
                end
            end
        end
    end

    assign bus.Port80Data = p80_data;
    assign bus.Port80Vld  = p80_vld;
`endif

    assign bus.DevAddr    = dev_addr;
    assign bus.WrDev_Data = wr_data;
    assign bus.Busy       = state != IDLE;
endmodule
